// File: rtl/serial_add_pkg.sv
// Shared types and sizing helpers for the bit-serial adder sequencer.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit counter must be able to hold the value WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/fa_cell.sv
// Combinational 1-bit full adder assembled from two half-adder stages.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic s1;
  logic c1;
  logic c2;

  assign s1   = a ^ b;
  assign c1   = a & b;
  assign sum  = s1 ^ cin;
  assign c2   = s1 & cin;
  assign cout = c1 | c2;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: one shared fa_cell walks the operands LSB first.
// Define SERIAL_ADD_OVF_EN to add the signed-overflow output V.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             C,
`ifdef SERIAL_ADD_OVF_EN
  output logic             V,
`endif
  output logic             busy
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_MSB  = CNT_W'(WIDTH - 1);

  state_t           state_reg;
  logic [WIDTH-1:0] a_sh_reg;
  logic [WIDTH-1:0] b_sh_reg;
  logic [WIDTH-1:0] sum_sh_reg;
  logic [WIDTH-1:0] sum_shift;
  logic [CNT_W-1:0] cnt_reg;
  logic             carry_reg;
  logic [WIDTH-1:0] s_reg;
  logic             c_reg;
  logic             in_ready_reg;
  logic             out_valid_reg;
  logic             busy_reg;
  logic             sum_bit;
  logic             cout_bit;
`ifdef SERIAL_ADD_OVF_EN
  logic             msb_cin_reg;
  logic             v_reg;
`endif

  fa_cell u_fa (
    .a   (a_sh_reg[0]),
    .b   (b_sh_reg[0]),
    .cin (carry_reg),
    .sum (sum_bit),
    .cout(cout_bit)
  );

  // New sum bit enters at the MSB so the LSB-first result lands in place.
  always_comb begin
    sum_shift            = sum_sh_reg >> 1;
    sum_shift[WIDTH-1]   = sum_bit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      a_sh_reg      <= '0;
      b_sh_reg      <= '0;
      sum_sh_reg    <= '0;
      cnt_reg       <= '0;
      carry_reg     <= 1'b0;
      s_reg         <= '0;
      c_reg         <= 1'b0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      msb_cin_reg   <= 1'b0;
      v_reg         <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_sh_reg     <= A;
            b_sh_reg     <= B;
            sum_sh_reg   <= '0;
            carry_reg    <= 1'b0;
            cnt_reg      <= '0;
            state_reg    <= RUN;
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b1;
          end
        end
        RUN: begin
          if (cnt_reg == CNT_LAST) begin
            // All bits consumed: publish the result on the transition edge.
            state_reg     <= DONE;
            s_reg         <= sum_sh_reg;
            c_reg         <= carry_reg;
            out_valid_reg <= 1'b1;
`ifdef SERIAL_ADD_OVF_EN
            v_reg         <= msb_cin_reg ^ carry_reg;
`endif
          end else begin
            a_sh_reg   <= a_sh_reg >> 1;
            b_sh_reg   <= b_sh_reg >> 1;
            sum_sh_reg <= sum_shift;
            carry_reg  <= cout_bit;
            cnt_reg    <= cnt_reg + CNT_W'(1);
`ifdef SERIAL_ADD_OVF_EN
            if (cnt_reg == CNT_MSB) begin
              msb_cin_reg <= carry_reg;
            end
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            in_ready_reg  <= 1'b1;
          end
        end
        default: begin
          state_reg     <= IDLE;
          out_valid_reg <= 1'b0;
          busy_reg      <= 1'b0;
          in_ready_reg  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign busy      = busy_reg;
  assign S         = s_reg;
  assign C         = c_reg;
`ifdef SERIAL_ADD_OVF_EN
  assign V         = v_reg;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8) against an arithmetic model.
// Covers SERIAL_ADD_OVF_EN when that macro is defined for the build.
module tb_serial_add_ctrl;

  localparam int WIDTH = 8;
  localparam int LAT   = WIDTH + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a_in = '0;
  logic [WIDTH-1:0] b_in = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] s_out;
  logic             c_out;
  logic             busy;
`ifdef SERIAL_ADD_OVF_EN
  logic             v_out;
`endif

  int total = 0;
  int bad   = 0;

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (a_in),
    .B        (b_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .S        (s_out),
    .C        (c_out),
`ifdef SERIAL_ADD_OVF_EN
    .V        (v_out),
`endif
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: unsigned sum with carry, and signed overflow from operand signs.
  function automatic logic [WIDTH:0] model_sum(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  function automatic logic model_ovf(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] s;
    s = a + b;
    return (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
  endfunction

  // Drives one transaction from IDLE and reports what came out (no checking here).
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int hold,
                        output logic [WIDTH-1:0] s, output logic c, output logic v,
                        output int lat, output logic timeout);
    a_in = a; b_in = b; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    a_in = $urandom; b_in = $urandom;
    lat = 0;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
    timeout = !out_valid;
    s = s_out;
    c = c_out;
`ifdef SERIAL_ADD_OVF_EN
    v = v_out;
`else
    v = 1'b0;
`endif
    repeat (hold) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || s_out !== '0 || c_out !== 1'b0) begin
      bad++;
      $display("FAIL reset: in_ready=%b out_valid=%b busy=%b S=%h C=%b want 1 0 0 00 0",
               in_ready, out_valid, busy, s_out, c_out);
    end
`ifdef SERIAL_ADD_OVF_EN
    total++;
    if (v_out !== 1'b0) begin
      bad++;
      $display("FAIL reset_v: V=%b want 0", v_out);
    end
`endif
    $display("reset checked");
  endtask

  task automatic test_basic_timing();
    int first_valid;
    a_in = 8'h5A; b_in = 8'h3C; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    first_valid = -1;
    for (int e = 1; e <= LAT; e++) begin
      tick();
      if (out_valid === 1'b1 && first_valid < 0) first_valid = e;
    end
    total++;
    if (first_valid != LAT) begin
      bad++;
      $display("FAIL basic_latency: out_valid first after edge %0d want %0d", first_valid, LAT);
    end
    total++;
    if (s_out !== 8'h96 || c_out !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL basic_result: S=%h C=%b in_ready=%b busy=%b want 96 0 0 1",
               s_out, c_out, in_ready, busy);
    end
    tick();
    out_ready = 1'b0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || s_out !== 8'h96) begin
      bad++;
      $display("FAIL basic_return: in_ready=%b out_valid=%b busy=%b S=%h want 1 0 0 96",
               in_ready, out_valid, busy, s_out);
    end
    $display("op 5a+3c -> S=%h C=%b", s_out, c_out);
  endtask

  task automatic test_vectors();
    logic [WIDTH-1:0] av [4] = '{8'hFF, 8'h00, 8'h7F, 8'h80};
    logic [WIDTH-1:0] bv [4] = '{8'h01, 8'h00, 8'h01, 8'h80};
    logic [WIDTH-1:0] s;
    logic c, v, to;
    logic [WIDTH:0] exp;
    int lat;
    for (int i = 0; i < 4; i++) begin
      run_op(av[i], bv[i], 0, s, c, v, lat, to);
      exp = model_sum(av[i], bv[i]);
      total++;
      if (to || {c, s} !== exp || lat != LAT) begin
        bad++;
        $display("FAIL vector_%0d: %h+%h got C=%b S=%h lat=%0d want C=%b S=%h lat=%0d",
                 i, av[i], bv[i], c, s, lat, exp[WIDTH], exp[WIDTH-1:0], LAT);
      end
      $display("op %h+%h -> S=%h C=%b", av[i], bv[i], s, c);
    end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] a, b, s;
    logic c, v, to;
    logic [WIDTH:0] exp;
    int lat;
    for (int i = 0; i < 24; i++) begin
      a = $urandom; b = $urandom;
      run_op(a, b, $urandom_range(0, 3), s, c, v, lat, to);
      exp = model_sum(a, b);
      total++;
      if (to || {c, s} !== exp || lat != LAT) begin
        bad++;
        $display("FAIL random_%0d: %h+%h got C=%b S=%h lat=%0d want C=%b S=%h lat=%0d",
                 i, a, b, c, s, lat, exp[WIDTH], exp[WIDTH-1:0], LAT);
      end
`ifdef SERIAL_ADD_OVF_EN
      total++;
      if (v !== model_ovf(a, b)) begin
        bad++;
        $display("FAIL random_v_%0d: %h+%h got V=%b want %b", i, a, b, v, model_ovf(a, b));
      end
`endif
      $display("op %h+%h -> S=%h C=%b V=%b", a, b, s, c, v);
    end
  endtask

  task automatic test_backpressure();
    int waited;
    a_in = 8'h12; b_in = 8'h34; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    // Stray request mid-RUN must be ignored.
    a_in = 8'hF0; b_in = 8'hF0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    waited = 0;
    while (!out_valid && waited < 50) begin
      tick();
      waited++;
    end
    total++;
    if (!out_valid || s_out !== 8'h46 || c_out !== 1'b0) begin
      bad++;
      $display("FAIL bp_result: out_valid=%b S=%h C=%b want 1 46 0", out_valid, s_out, c_out);
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || s_out !== 8'h46 || c_out !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold_%0d: out_valid=%b in_ready=%b S=%h C=%b want 1 0 46 0",
                 k, out_valid, in_ready, s_out, c_out);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
    $display("op 12+34 under backpressure -> S=%h C=%b", s_out, c_out);
  endtask

  task automatic test_reset_mid();
    logic [WIDTH-1:0] s;
    logic c, v, to;
    int lat;
    a_in = 8'hC3; b_in = 8'h5D; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    total++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL mid_busy: busy=%b in_ready=%b want 1 0", busy, in_ready);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (out_valid !== 1'b0 || s_out !== '0 || c_out !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: out_valid=%b S=%h C=%b in_ready=%b busy=%b want 0 00 0 1 0",
               out_valid, s_out, c_out, in_ready, busy);
    end
    repeat (12) begin
      tick();
      if (out_valid !== 1'b0) break;
    end
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL mid_noresult: out_valid=%b want 0", out_valid);
    end
    run_op(8'h10, 8'h20, 0, s, c, v, lat, to);
    total++;
    if (to || s !== 8'h30 || c !== 1'b0) begin
      bad++;
      $display("FAIL mid_after: S=%h C=%b want 30 0", s, c);
    end
    $display("op 10+20 after abort -> S=%h C=%b", s, c);
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] av [3] = '{8'h01, 8'h80, 8'h7F};
    logic [WIDTH-1:0] bv [3] = '{8'h01, 8'h80, 8'h01};
    logic [WIDTH:0] exp;
    int acc_idx, res_idx, cyc, last_cyc;
    logic acc;
    acc_idx = 0; res_idx = 0; cyc = 0; last_cyc = -1;
    a_in = av[0]; b_in = bv[0]; in_valid = 1'b1; out_ready = 1'b1;
    while (res_idx < 3 && cyc < 200) begin
      acc = in_ready && in_valid;
      tick();
      cyc++;
      if (acc) begin
        acc_idx++;
        if (acc_idx < 3) begin
          a_in = av[acc_idx]; b_in = bv[acc_idx];
        end else begin
          in_valid = 1'b0;
        end
      end
      if (out_valid) begin
        exp = model_sum(av[res_idx], bv[res_idx]);
        total++;
        if ({c_out, s_out} !== exp || (last_cyc >= 0 && cyc - last_cyc < WIDTH + 2)) begin
          bad++;
          $display("FAIL b2b_%0d: C=%b S=%h gap=%0d want C=%b S=%h gap>=%0d",
                   res_idx, c_out, s_out, cyc - last_cyc, exp[WIDTH], exp[WIDTH-1:0], WIDTH + 2);
        end
        $display("op %h+%h back-to-back -> S=%h C=%b at cycle %0d",
                 av[res_idx], bv[res_idx], s_out, c_out, cyc);
        last_cyc = cyc;
        res_idx++;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    total++;
    if (res_idx != 3) begin
      bad++;
      $display("FAIL b2b_count: results=%0d want 3", res_idx);
    end
    repeat (2) tick();
  endtask

`ifdef SERIAL_ADD_OVF_EN
  task automatic test_ovf();
    logic [WIDTH-1:0] av [3] = '{8'h7F, 8'h80, 8'h10};
    logic [WIDTH-1:0] bv [3] = '{8'h01, 8'h80, 8'h20};
    logic [WIDTH-1:0] s;
    logic c, v, to;
    logic [WIDTH:0] exp;
    int lat;
    for (int i = 0; i < 3; i++) begin
      run_op(av[i], bv[i], 1, s, c, v, lat, to);
      exp = model_sum(av[i], bv[i]);
      total++;
      if (to || v !== model_ovf(av[i], bv[i]) || c !== exp[WIDTH]) begin
        bad++;
        $display("FAIL ovf_%0d: %h+%h got V=%b C=%b want V=%b C=%b",
                 i, av[i], bv[i], v, c, model_ovf(av[i], bv[i]), exp[WIDTH]);
      end
      $display("op %h+%h -> V=%b C=%b", av[i], bv[i], v, c);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_timing();
    test_vectors();
    test_random();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
`ifdef SERIAL_ADD_OVF_EN
    test_ovf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
